cmp_slice_seq: RTL and testbench

//  Iterative 32-bit compare sequencer. It drives one shared narrow slice comparator over several cycles, MSB slice first.

---
 rtl/cmp_slice_seq_if.sv | 26 ++
 rtl/cmp_slice_seq.sv | 137 +++++++++++++
 tb/tb_cmp_slice_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cmp_slice_seq_if.sv
// Request/response handshake bundle for the iterative slice compare sequencer.
// The master modport is the requester; the slave modport is the sequencer.
interface cmp_slice_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_signed;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_eq;
  logic             rsp_lt;
  logic             rsp_gt;

  modport master (
    output req_valid, req_a, req_b, req_signed, rsp_ready,
    input  req_ready, rsp_valid, rsp_eq, rsp_lt, rsp_gt
  );

  modport slave (
    input  req_valid, req_a, req_b, req_signed, rsp_ready,
    output req_ready, rsp_valid, rsp_eq, rsp_lt, rsp_gt
  );
endinterface

// File: rtl/cmp_slice_seq.sv
// Iterative compare sequencer: walks one shared external SLICE-bit comparator over the latched
// operands, MSB slice first, and accumulates a sticky EQ/LT/GT decision.
// Optional feature: define CMP_EARLY_EXIT_EN to leave the scan at the first unequal slice.
module cmp_slice_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  cmp_slice_seq_if.slave   bus,
  output logic [SLICE-1:0] slc_a,
  output logic [SLICE-1:0] slc_b,
  input  logic             slc_eq,
  input  logic             slc_gt,
  input  logic             slc_lt,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NSLICE - 1);
  localparam logic [SLICE-1:0] MSB_MASK = SLICE'(1) << (SLICE - 1);

  if (WIDTH % SLICE != 0) begin : gen_width_check
    $error("cmp_slice_seq: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

  state_e          state_q;
  logic [IDXW-1:0] idx_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic            signed_q;
  logic            decided_q, dec_lt_q, dec_gt_q;
  logic            req_ready_q, rsp_valid_q, rsp_eq_q, rsp_lt_q, rsp_gt_q, busy_q;

  logic [SLICE-1:0] raw_a, raw_b;
  logic             bias;
  logic             dec_now, nxt_decided, nxt_lt, nxt_gt, exit_cmp;

  // Slice presented to the external comparator; sign bias flips the MSBs of the top slice.
  always_comb begin
    raw_a = SLICE'(a_q >> (32'(idx_q) * SLICE));
    raw_b = SLICE'(b_q >> (32'(idx_q) * SLICE));
    bias  = signed_q && (idx_q == IDX_TOP);
    slc_a = '0;
    slc_b = '0;
    if (state_q == StCmp) begin
      slc_a = raw_a ^ (bias ? MSB_MASK : '0);
      slc_b = raw_b ^ (bias ? MSB_MASK : '0);
    end
  end

  // Sticky decision update; eq outranks gt, gt outranks lt on malformed comparator outputs.
  always_comb begin
    dec_now     = !decided_q && !slc_eq;
    nxt_decided = decided_q | dec_now;
    nxt_gt      = dec_now ? slc_gt : dec_gt_q;
    nxt_lt      = dec_now ? (slc_lt & ~slc_gt) : dec_lt_q;
`ifdef CMP_EARLY_EXIT_EN
    exit_cmp    = (idx_q == '0) || dec_now;
`else
    exit_cmp    = (idx_q == '0);
`endif
  end

  // Control FSM with all handshake/result outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= IDX_TOP;
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      decided_q   <= 1'b0;
      dec_lt_q    <= 1'b0;
      dec_gt_q    <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_eq_q    <= 1'b0;
      rsp_lt_q    <= 1'b0;
      rsp_gt_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            a_q         <= bus.req_a;
            b_q         <= bus.req_b;
            signed_q    <= bus.req_signed;
            idx_q       <= IDX_TOP;
            decided_q   <= 1'b0;
            dec_lt_q    <= 1'b0;
            dec_gt_q    <= 1'b0;
            rsp_eq_q    <= 1'b0;
            rsp_lt_q    <= 1'b0;
            rsp_gt_q    <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StCmp;
          end
        end
        StCmp: begin
          decided_q <= nxt_decided;
          dec_lt_q  <= nxt_lt;
          dec_gt_q  <= nxt_gt;
          if (exit_cmp) begin
            rsp_valid_q <= 1'b1;
            rsp_eq_q    <= !nxt_decided;
            rsp_lt_q    <= nxt_lt;
            rsp_gt_q    <= nxt_gt;
            state_q     <= StDone;
          end else begin
            idx_q <= idx_q - IDXW'(1);
          end
        end
        StDone: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_eq    = rsp_eq_q;
  assign bus.rsp_lt    = rsp_lt_q;
  assign bus.rsp_gt    = rsp_gt_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_cmp_slice_seq.sv
// Directed bench for cmp_slice_seq with a behavioural 4-bit slice comparator.
module tb_cmp_slice_seq;

`ifdef CMP_EARLY_EXIT_EN
  localparam int LAT_TOP = 1;
  localparam int LAT_I2  = 6;
`else
  localparam int LAT_TOP = 8;
  localparam int LAT_I2  = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] slc_a, slc_b;
  logic       slc_eq, slc_gt, slc_lt;
  logic       busy;

  int checks = 0;
  int errors = 0;

  cmp_slice_seq_if #(.WIDTH(32)) bus ();

  cmp_slice_seq #(.WIDTH(32), .SLICE(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .slc_a  (slc_a),
    .slc_b  (slc_b),
    .slc_eq (slc_eq),
    .slc_gt (slc_gt),
    .slc_lt (slc_lt),
    .busy   (busy)
  );

  // External slice comparator.
  assign slc_eq = (slc_a == slc_b);
  assign slc_gt = (slc_a > slc_b);
  assign slc_lt = (slc_a < slc_b);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE; returns one cycle after the accept edge (first CMP cycle).
  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    bus.req_a      = a;
    bus.req_b      = b;
    bus.req_signed = sgn;
    bus.req_valid  = 1'b1;
    step();
    bus.req_valid  = 1'b0;
  endtask

  // Count edges after the accept edge until rsp_valid, bounded.
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (lat == 0) begin
        step();
        if (bus.rsp_valid) lat = k;
      end
    end
  endtask

  // Flags packed as {eq, lt, gt}; rsp_ready assumed high, ends back in IDLE.
  task automatic get_rsp(input string tag, input int exp_lat, input logic [2:0] exp_flags);
    int lat;
    wait_rsp(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_flags"}, {bus.rsp_eq, bus.rsp_lt, bus.rsp_gt}, exp_flags);
    step();
  endtask

  initial begin
    int lat;
    int rr_seen;
    bus.req_valid  = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_signed = 1'b0;
    bus.rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus.req_ready, 1);
    check("rst_outs", {bus.rsp_valid, bus.rsp_eq, bus.rsp_lt, bus.rsp_gt, busy}, 0);
    check("rst_slc", {slc_a, slc_b}, 0);
    rst_n = 1'b1;
    step();

    // 1: equal operands
    start(32'h1234_5678, 32'h1234_5678, 1'b0);
    check("t1_busy", {busy, bus.req_ready}, 2'b10);
    get_rsp("t1", 8, 3'b100);

    // 2: -1 vs 1 signed, then unsigned
    start(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    check("t2s_slc_a", slc_a, 4'h7);
    check("t2s_slc_b", slc_b, 4'h8);
    get_rsp("t2s", LAT_TOP, 3'b010);
    start(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check("t2u_slc", {slc_a, slc_b}, 8'hF0);
    get_rsp("t2u", LAT_TOP, 3'b001);

    // 3: MSB-only difference
    start(32'h8000_0000, 32'h0000_0000, 1'b0);
    get_rsp("t3", LAT_TOP, 3'b001);

    // 4: backpressure in DONE
    bus.rsp_ready = 1'b0;
    start(32'h0000_0010, 32'h0000_0011, 1'b0);
    wait_rsp(lat);
    check("t4_lat", lat, 8);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold", {bus.rsp_valid, bus.rsp_eq, bus.rsp_lt, bus.rsp_gt, busy}, 5'b10101);
      step();
    end
    check("t4_hold_end", {bus.rsp_valid, bus.rsp_lt}, 2'b11);
    bus.rsp_ready = 1'b1;
    step();
    check("t4_idle", {bus.rsp_valid, bus.req_ready, busy}, 3'b010);
    check("t4_flags_kept", {bus.rsp_eq, bus.rsp_lt, bus.rsp_gt}, 3'b010);

    // 5: request held high with new operands while busy
    bus.req_a      = 32'h0000_0005;
    bus.req_b      = 32'h0000_0003;
    bus.req_signed = 1'b0;
    bus.req_valid  = 1'b1;
    step();
    bus.req_a = 32'h0000_0003;
    bus.req_b = 32'h0000_0005;
    rr_seen = 0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (lat == 0) begin
        if (bus.req_ready) rr_seen++;
        step();
        if (bus.rsp_valid) lat = k;
      end
    end
    check("t5_ready_low", rr_seen, 0);
    check("t5a_lat", lat, 8);
    check("t5a_flags", {bus.rsp_eq, bus.rsp_lt, bus.rsp_gt}, 3'b001);
    step();
    check("t5_idle", {bus.req_ready, busy}, 2'b10);
    step();
    bus.req_valid = 1'b0;
    check("t5b_busy", busy, 1);
    get_rsp("t5b", 8, 3'b010);

    // 6: reset on the third CMP cycle
    start(32'h1234_5678, 32'h1234_5679, 1'b0);
    step();
    step();
    check("t6_mid", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_outs", {bus.rsp_valid, bus.rsp_eq, bus.rsp_lt, bus.rsp_gt, busy}, 0);
    check("t6_rst_slc", {slc_a, slc_b}, 0);
    check("t6_rst_ready", bus.req_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    check("t6_after", {bus.req_ready, bus.rsp_valid}, 2'b10);
    start(32'h0000_0100, 32'h0000_0200, 1'b0);
    get_rsp("t6", LAT_I2, 3'b010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
